jtopl_wrseq: RTL and testbench
==============================

JTOPL_WRSEQ -- requirements
Module: jtopl_wrseq

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all state on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port cen, input, 1 bit: clock enable of the operator slot counter.
REQ-004 SHALL have port wr, input, 1 bit: one-clk CPU write strobe.
REQ-005 SHALL have port addr, input, 1 bit: 0 = address port, 1 = data port.
REQ-006 SHALL have port cpu_din, input, 8 bits: CPU write data.
REQ-007 SHALL have port slot, input, 18 bits: one-hot active slot from the register datapath.
REQ-008 SHALL have port din, output, 8 bits: held data towards the register datapath.
REQ-009 SHALL have port write, output, 1 bit: a datapath write is pending.
REQ-010 SHALL have ports sel_group (2 bits) and sel_sub (3 bits), outputs: target group and subslot.
REQ-011 SHALL have ports up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_fnumlo, up_fnumhi, up_fbcon, outputs, 1 bit each: at most one high.
REQ-012 SHALL have ports rhy_en (1), rhy_kon (5), am_dep (1), vib_dep (1), outputs: register 0xBD fields.
REQ-013 SHALL have ports busy (1) and overrun (1), outputs: pending write; sticky dropped-write flag.

Function
REQ-014 SHALL latch cpu_din into an 8-bit index on wr with addr=0, in any state.
REQ-015 SHALL decode wr with addr=1 by index: 0x20/0x40/0x60/0x80 bases plus offset o in 0x00-0x15 select up_mult/up_ksl_tl/up_ar_dr/up_sl_rr, with sel_group=o[4:3] and sel_sub=o[2:0].
REQ-016 SHALL treat operator offsets with o[2:0] of 6 or 7 as invalid and ignore them.
REQ-017 SHALL decode 0xA0/0xB0/0xC0 plus c in 0-8 as up_fnumlo/up_fnumhi/up_fbcon, with sel_group=c/3 and sel_sub=c%3.
REQ-018 SHALL write index 0xBD directly in the same cycle, in any state and without the datapath: am_dep=bit7, vib_dep=bit6, rhy_en=bit5, rhy_kon=bits4:0.
REQ-019 SHALL ignore data writes to any other index, with no state change.
REQ-020 SHALL use a two-state FSM: IDLE and WAIT.
REQ-021 In IDLE, an accepted datapath write SHALL register din, sel_*, and one up_* strobe, set write=busy=1, and go to WAIT on the next clk.
REQ-022 In WAIT, on a clk with cen=1 and slot[6*sel_group+sel_sub]=1, the FSM SHALL consume the write: next clk write=busy=0, all up_*=0, state IDLE.
REQ-023 WAIT SHALL ignore cycles with cen=0, so completion latency is 1 to 18 cen cycles.
REQ-024 A datapath write SHALL be accepted only when registered busy=0 in that cycle, including a cycle that is itself completing.
REQ-025 Otherwise the write SHALL be dropped and overrun set to 1 (see REQ-030).
REQ-026 overrun SHALL clear only on reset.
REQ-027 sel_group, sel_sub and din SHALL hold stable throughout WAIT.

Reset
REQ-028 On rst=0 all outputs, the index, the FSM (IDLE) and any queued entry SHALL clear to 0 asynchronously.
REQ-029 A write pending when reset asserts SHALL be discarded, with no strobe after release.

Configuration
REQ-030 Macro JTOPL_WRSEQ_QUEUE_EN SHALL add a one-entry queue.
REQ-031 With the macro, a datapath write while busy=1 SHALL be queued if the queue is empty; if it is full, the write SHALL be dropped and overrun set.
REQ-032 With the macro, on the completion clk a queued entry SHALL load into the outputs, with write and busy staying 1 and WAIT re-entered without an IDLE cycle.
REQ-033 Without the macro, every datapath write while busy=1 SHALL be dropped and overrun set.

Verification
REQ-034 Index 0x43, data 0x3F, cen always 1 -> up_ksl_tl=1, sel_group=0, sel_sub=3, din=0x3F until the clk with slot[3]=1; write=0 the next clk.
REQ-035 Index 0xB7, data 0x2A -> up_fnumhi with sel_group=2, sel_sub=1, completing on slot[13]; with cen low half the time, completion takes 1-18 cen cycles.
REQ-036 Index 0x26, then 0xA9, then 0xF0, with data writes -> no strobe, busy=0, overrun=0.
REQ-037 Index 0xBD, data 0x3F while busy=1 -> rhy_en=1, rhy_kon=0x1F next clk; the pending write is unaffected.
REQ-038 Two data writes back to back: without the macro, the second is dropped and overrun=1; with the macro, the second completes after the first and a third write sets overrun=1.
REQ-039 rst=0 during WAIT -> all outputs 0 immediately; after release, no up_* strobe occurs even when the target slot comes round.

Source files
------------

// File: rtl/jtopl_wrseq.sv
// jtopl_wrseq: CPU write sequencer for the OPL register datapath.
// The CPU writes an index (addr=0) and then data (addr=1). Operator and
// channel registers are held until the addressed slot comes round, and
// register 0xBD is written straight away.
// Optional feature: define JTOPL_WRSEQ_QUEUE_EN to add a one-entry queue
// that takes one extra datapath write while another is still pending.
module jtopl_wrseq (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        wr,
  input  logic        addr,
  input  logic [7:0]  cpu_din,
  input  logic [17:0] slot,
  output logic [7:0]  din,
  output logic        write,
  output logic [1:0]  sel_group,
  output logic [2:0]  sel_sub,
  output logic        up_mult,
  output logic        up_ksl_tl,
  output logic        up_ar_dr,
  output logic        up_sl_rr,
  output logic        up_fnumlo,
  output logic        up_fnumhi,
  output logic        up_fbcon,
  output logic        rhy_en,
  output logic [4:0]  rhy_kon,
  output logic        am_dep,
  output logic        vib_dep,
  output logic        busy,
  output logic        overrun
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0] r_state;
  logic [7:0] r_index;
  logic [7:0] r_bd;
  logic [7:0] r_din;
  logic [1:0] r_group;
  logic [2:0] r_sub;
  logic [6:0] r_up;
  logic       r_overrun;

`ifdef JTOPL_WRSEQ_QUEUE_EN
  logic       r_qValid;
  logic [7:0] r_qDin;
  logic [1:0] r_qGroup;
  logic [2:0] r_qSub;
  logic [6:0] r_qUp;
`endif

  logic       w_opOk;
  logic       w_chOk;
  logic [1:0] w_chGroup;
  logic [2:0] w_chSub;
  logic [6:0] w_up;
  logic [1:0] w_group;
  logic [2:0] w_sub;
  logic       w_dpWrite;
  logic       w_bdWrite;
  logic [4:0] w_slotIdx;
  logic [31:0] w_slotExt;
  logic       w_done;

  // Operator offsets 0x18-0x1F and subslots 6/7 do not exist.
  assign w_opOk = (r_index[4:3] != 2'b11) && (r_index[2:1] != 2'b11);
  // Only channels 0-8 exist.
  assign w_chOk = (r_index[3:0] <= 4'd8);

  // Channel number to group (c/3) and subslot (c%3).
  always_comb begin
    w_chGroup = 2'd0;
    w_chSub   = 3'd0;
    case (r_index[3:0])
      4'd0: begin w_chGroup = 2'd0; w_chSub = 3'd0; end
      4'd1: begin w_chGroup = 2'd0; w_chSub = 3'd1; end
      4'd2: begin w_chGroup = 2'd0; w_chSub = 3'd2; end
      4'd3: begin w_chGroup = 2'd1; w_chSub = 3'd0; end
      4'd4: begin w_chGroup = 2'd1; w_chSub = 3'd1; end
      4'd5: begin w_chGroup = 2'd1; w_chSub = 3'd2; end
      4'd6: begin w_chGroup = 2'd2; w_chSub = 3'd0; end
      4'd7: begin w_chGroup = 2'd2; w_chSub = 3'd1; end
      4'd8: begin w_chGroup = 2'd2; w_chSub = 3'd2; end
      default: begin w_chGroup = 2'd0; w_chSub = 3'd0; end
    endcase
  end

  // Decode the current index into a one-hot update strobe and target slot.
  always_comb begin
    w_up    = 7'b0000000;
    w_group = 2'd0;
    w_sub   = 3'd0;
    case (r_index[7:5])
      3'd1: if (w_opOk) begin
        w_up = 7'b0000001; w_group = r_index[4:3]; w_sub = r_index[2:0];
      end
      3'd2: if (w_opOk) begin
        w_up = 7'b0000010; w_group = r_index[4:3]; w_sub = r_index[2:0];
      end
      3'd3: if (w_opOk) begin
        w_up = 7'b0000100; w_group = r_index[4:3]; w_sub = r_index[2:0];
      end
      3'd4: if (w_opOk) begin
        w_up = 7'b0001000; w_group = r_index[4:3]; w_sub = r_index[2:0];
      end
      3'd5, 3'd6: if (w_chOk) begin
        case (r_index[7:4])
          4'hA:    w_up = 7'b0010000;
          4'hB:    w_up = 7'b0100000;
          4'hC:    w_up = 7'b1000000;
          default: w_up = 7'b0000000;
        endcase
        w_group = w_chGroup;
        w_sub   = w_chSub;
      end
      default: w_up = 7'b0000000;
    endcase
  end

  assign w_dpWrite = wr & addr & (|w_up);
  assign w_bdWrite = wr & addr & (r_index == 8'hBD);

  // Slots are numbered 6*group+subslot; padding keeps the lookup in range.
  assign w_slotIdx = ({3'b000, r_group} * 5'd6) + {2'b00, r_sub};
  assign w_slotExt = {14'd0, slot};
  assign w_done    = (r_state == ST_WAIT) & cen & w_slotExt[w_slotIdx];

  // Index latch and the directly written 0xBD register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_index <= 8'd0;
      r_bd    <= 8'd0;
    end else begin
      if (wr && !addr) r_index <= cpu_din;
      if (w_bdWrite)   r_bd    <= cpu_din;
    end
  end

  // Pending-write FSM: hold the write until its slot comes round with cen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_din     <= 8'd0;
      r_group   <= 2'd0;
      r_sub     <= 3'd0;
      r_up      <= 7'd0;
      r_overrun <= 1'b0;
`ifdef JTOPL_WRSEQ_QUEUE_EN
      r_qValid  <= 1'b0;
      r_qDin    <= 8'd0;
      r_qGroup  <= 2'd0;
      r_qSub    <= 3'd0;
      r_qUp     <= 7'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_dpWrite) begin
            r_din   <= cpu_din;
            r_group <= w_group;
            r_sub   <= w_sub;
            r_up    <= w_up;
            r_state <= ST_WAIT;
          end
        end
        default: begin
`ifdef JTOPL_WRSEQ_QUEUE_EN
          // A write arriving on the completion cycle with an empty queue
          // goes straight to the outputs instead of parking in the queue.
          if (w_dpWrite) begin
            if (r_qValid) begin
              r_overrun <= 1'b1;
            end else if (!w_done) begin
              r_qValid <= 1'b1;
              r_qDin   <= cpu_din;
              r_qGroup <= w_group;
              r_qSub   <= w_sub;
              r_qUp    <= w_up;
            end
          end
          if (w_done) begin
            if (r_qValid) begin
              r_din    <= r_qDin;
              r_group  <= r_qGroup;
              r_sub    <= r_qSub;
              r_up     <= r_qUp;
              r_qValid <= 1'b0;
            end else if (w_dpWrite) begin
              r_din   <= cpu_din;
              r_group <= w_group;
              r_sub   <= w_sub;
              r_up    <= w_up;
            end else begin
              r_up    <= 7'd0;
              r_state <= ST_IDLE;
            end
          end
`else
          if (w_dpWrite) r_overrun <= 1'b1;
          if (w_done) begin
            r_up    <= 7'd0;
            r_state <= ST_IDLE;
          end
`endif
        end
      endcase
    end
  end

  assign din       = r_din;
  assign write     = r_state;
  assign busy      = r_state;
  assign sel_group = r_group;
  assign sel_sub   = r_sub;
  assign up_mult   = r_up[0];
  assign up_ksl_tl = r_up[1];
  assign up_ar_dr  = r_up[2];
  assign up_sl_rr  = r_up[3];
  assign up_fnumlo = r_up[4];
  assign up_fnumhi = r_up[5];
  assign up_fbcon  = r_up[6];
  assign am_dep    = r_bd[7];
  assign vib_dep   = r_bd[6];
  assign rhy_en    = r_bd[5];
  assign rhy_kon   = r_bd[4:0];
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_jtopl_wrseq.sv
// tb_jtopl_wrseq: bench for jtopl_wrseq with a transaction-level model.
// Honours JTOPL_WRSEQ_QUEUE_EN the same way as the design.
`timescale 1ns/1ps
module tb_jtopl_wrseq;

`ifdef JTOPL_WRSEQ_QUEUE_EN
  localparam int Cap = 2;
`else
  localparam int Cap = 1;
`endif

  typedef struct {
    logic [7:0] d;
    int         grp;
    int         sub;
    int         kind;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cen = 1'b0;
  logic        wr = 1'b0;
  logic        addr = 1'b0;
  logic [7:0]  cpu_din = 8'd0;
  logic [17:0] slot = 18'd1;
  logic [7:0]  din;
  logic        write;
  logic [1:0]  sel_group;
  logic [2:0]  sel_sub;
  logic        up_mult, up_ksl_tl, up_ar_dr, up_sl_rr;
  logic        up_fnumlo, up_fnumhi, up_fbcon;
  logic        rhy_en;
  logic [4:0]  rhy_kon;
  logic        am_dep, vib_dep;
  logic        busy, overrun;
  logic [6:0]  dutUp;

  int errorCount = 0;
  int checkCount = 0;
  bit checkEn = 0;
  int cenMode = 1;
  int slotIdx = 0;
  int cenCnt;

  // Model state: queue of pending writes, front is on the outputs.
  entry_t     pend[$];
  entry_t     mEntry;
  logic [7:0] mIdx = 8'd0;
  logic [7:0] mBd = 8'd0;
  bit         mOver = 0;
  bit         mDone;
  int         mT;

  jtopl_wrseq dut (
    .clk(clk), .rst(rst), .cen(cen), .wr(wr), .addr(addr),
    .cpu_din(cpu_din), .slot(slot), .din(din), .write(write),
    .sel_group(sel_group), .sel_sub(sel_sub),
    .up_mult(up_mult), .up_ksl_tl(up_ksl_tl), .up_ar_dr(up_ar_dr),
    .up_sl_rr(up_sl_rr), .up_fnumlo(up_fnumlo), .up_fnumhi(up_fnumhi),
    .up_fbcon(up_fbcon), .rhy_en(rhy_en), .rhy_kon(rhy_kon),
    .am_dep(am_dep), .vib_dep(vib_dep), .busy(busy), .overrun(overrun)
  );

  assign dutUp = {up_fbcon, up_fnumhi, up_fnumlo, up_sl_rr, up_ar_dr, up_ksl_tl, up_mult};

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Register map from plain arithmetic on the index value.
  function automatic bit decodeWrite(input logic [7:0] idx, input logic [7:0] d, output entry_t e);
    int v, o, c;
    v = int'(idx);
    e.d = d; e.grp = 0; e.sub = 0; e.kind = 0;
    if (v >= 32 && v < 160) begin
      o = v % 32;
      if (o <= 21 && (o % 8) < 6) begin
        e.kind = v / 32 - 1; e.grp = o / 8; e.sub = o % 8;
        return 1'b1;
      end
      return 1'b0;
    end
    if (v >= 160 && v < 208) begin
      c = v % 16;
      if (c <= 8) begin
        e.kind = 4 + (v / 16 - 10); e.grp = c / 3; e.sub = c % 3;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Model update on each clock; reset empties everything at once.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend.delete();
      mIdx = 8'd0; mBd = 8'd0; mOver = 0;
    end else begin
      mDone = 0;
      if (pend.size() > 0) begin
        mT = 6 * pend[0].grp + pend[0].sub;
        mDone = cen && (((slot >> mT) & 18'd1) != 18'd0);
      end
      if (wr && !addr) mIdx = cpu_din;
      if (wr && addr) begin
        if (mIdx == 8'hBD) mBd = cpu_din;
        else if (decodeWrite(mIdx, cpu_din, mEntry)) begin
          if (pend.size() < Cap) pend.push_back(mEntry);
          else mOver = 1;
        end
      end
      if (mDone) void'(pend.pop_front());
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (checkEn && rst) begin
      checkOutput("busy", 32'(busy), 32'(pend.size() > 0));
      checkOutput("write", 32'(write), 32'(pend.size() > 0));
      checkOutput("up", 32'(dutUp), (pend.size() > 0) ? (32'd1 << pend[0].kind) : 32'd0);
      checkOutput("overrun", 32'(overrun), 32'(mOver));
      checkOutput("reg_bd", 32'({am_dep, vib_dep, rhy_en, rhy_kon}), 32'(mBd));
      if (pend.size() > 0) begin
        checkOutput("din", 32'(din), 32'(pend[0].d));
        checkOutput("sel", 32'({sel_group, sel_sub}), 32'(pend[0].grp * 8 + pend[0].sub));
      end
    end
  end

  task automatic applyStimulus(input logic wrV, input logic addrV, input logic [7:0] d);
    @(negedge clk);
    if (cen) slotIdx = (slotIdx + 1) % 18;
    case (cenMode)
      0:       cen = 1'b0;
      1:       cen = 1'b1;
      default: cen = 1'($urandom_range(0, 1));
    endcase
    slot = 18'd1 << slotIdx;
    wr = wrV; addr = addrV; cpu_din = d;
  endtask

  task automatic writeReg(input logic [7:0] idx, input logic [7:0] d);
    applyStimulus(1'b1, 1'b0, idx);
    applyStimulus(1'b1, 1'b1, d);
    applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic waitIdle(input string name, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!busy) break;
      applyStimulus(1'b0, 1'b0, 8'h00);
    end
    checkOutput(name, 32'(busy), 32'd0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    wr = 1'b0; addr = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_write", 32'(write), 32'd0);
    checkOutput("rst_up", 32'(dutUp), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [7:0] randomIndex();
    int k;
    k = $urandom_range(0, 3);
    case (k)
      0:       return 8'($urandom);
      1:       return 8'(32 + 32 * $urandom_range(0, 3) + $urandom_range(0, 23));
      2:       return 8'(160 + 16 * $urandom_range(0, 2) + $urandom_range(0, 9));
      default: return 8'hBD;
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_up", 32'(dutUp), 32'd0);
    checkOutput("reset_din", 32'(din), 32'd0);
    checkOutput("reset_bd", 32'({am_dep, vib_dep, rhy_en, rhy_kon}), 32'd0);
    checkOutput("reset_overrun", 32'(overrun), 32'd0);
    rst = 1'b1;
    checkEn = 1;

    // Operator write 0x43 with cen always high.
    cenMode = 1;
    writeReg(8'h43, 8'h3F);
    checkOutput("ksl_strobe", 32'(up_ksl_tl), 32'd1);
    checkOutput("ksl_group", 32'(sel_group), 32'd0);
    checkOutput("ksl_sub", 32'(sel_sub), 32'd3);
    checkOutput("ksl_din", 32'(din), 32'h3F);
    checkOutput("ksl_busy", 32'(busy), 32'd1);
    waitIdle("ksl_done", 40);
    checkOutput("ksl_cleared", 32'(up_ksl_tl), 32'd0);
    checkOutput("ksl_write_low", 32'(write), 32'd0);

    // Channel write 0xB7 with cen toggling randomly.
    cenMode = 2;
    writeReg(8'hB7, 8'h2A);
    checkOutput("fnumhi_strobe", 32'(up_fnumhi), 32'd1);
    checkOutput("fnumhi_group", 32'(sel_group), 32'd2);
    checkOutput("fnumhi_sub", 32'(sel_sub), 32'd1);
    checkOutput("fnumhi_din", 32'(din), 32'h2A);
    cenCnt = int'(cen);
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      if (!busy) break;
      if (cen) cenCnt++;
    end
    checkOutput("fnumhi_done", 32'(busy), 32'd0);
    checkOutput("fnumhi_latency_ok", 32'(cenCnt >= 1 && cenCnt <= 18), 32'd1);

    // Invalid indices are ignored.
    writeReg(8'h26, 8'h11);
    writeReg(8'hA9, 8'h22);
    writeReg(8'hF0, 8'h33);
    checkOutput("invalid_busy", 32'(busy), 32'd0);
    checkOutput("invalid_up", 32'(dutUp), 32'd0);
    checkOutput("invalid_overrun", 32'(overrun), 32'd0);

    // 0xBD written while a datapath write is pending.
    cenMode = 0;
    writeReg(8'h62, 8'h11);
    writeReg(8'hBD, 8'h3F);
    checkOutput("bd_rhy_en", 32'(rhy_en), 32'd1);
    checkOutput("bd_rhy_kon", 32'(rhy_kon), 32'h1F);
    checkOutput("bd_am_vib", 32'({am_dep, vib_dep}), 32'd0);
    checkOutput("bd_pending_busy", 32'(busy), 32'd1);
    checkOutput("bd_pending_up", 32'(up_ar_dr), 32'd1);
    checkOutput("bd_pending_din", 32'(din), 32'h11);

    // A second datapath write while busy.
    writeReg(8'h80, 8'h55);
`ifdef JTOPL_WRSEQ_QUEUE_EN
    checkOutput("second_queued_overrun", 32'(overrun), 32'd0);
    writeReg(8'hC4, 8'h77);
    checkOutput("third_overrun", 32'(overrun), 32'd1);
    cenMode = 1;
    for (int i = 0; i < 40; i++) begin
      if (!up_ar_dr) break;
      applyStimulus(1'b0, 1'b0, 8'h00);
    end
    checkOutput("queue_busy_kept", 32'(busy), 32'd1);
    checkOutput("queue_strobe", 32'(up_sl_rr), 32'd1);
    checkOutput("queue_din", 32'(din), 32'h55);
`else
    checkOutput("second_overrun", 32'(overrun), 32'd1);
    checkOutput("second_din_held", 32'(din), 32'h11);
    cenMode = 1;
`endif
    waitIdle("backtoback_done", 80);

    // Reset during WAIT discards the pending write.
    cenMode = 0;
    writeReg(8'h20, 8'h01);
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    pulseReset();
    checkOutput("post_reset_bd", 32'({am_dep, vib_dep, rhy_en, rhy_kon}), 32'd0);
    cenMode = 1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("post_reset_no_strobe", 32'(dutUp), 32'd0);
    end

    // Randomized traffic against the model.
    cenMode = 2;
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 399);
      if (r < 2) pulseReset();
      else if (r < 120) applyStimulus(1'b1, 1'b0, randomIndex());
      else if (r < 220) applyStimulus(1'b1, 1'b1, 8'($urandom));
      else applyStimulus(1'b0, 1'b0, 8'h00);
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
    cenMode = 1;
    waitIdle("final_idle", 80);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
